key_uart_decoder: RTL and testbench
===================================

Name: key_uart_decoder

Overview:
Receives a byte stream of key make/break events from the HPS over the internal UART. It maintains the 80-bit CPC key state vector consumed by the keyboard input of the CPC2 core. It sits beside the HPS MMIO interface and gives the key state a serial path, with frame checking and stuck-key timeout protection. The block contains an 8N1 oversampling receiver, a byte decoder and a key-state register.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate
TIMEOUT_CYC, 100000000, idle clocks after the last valid byte before all keys are forced released (2 s at 50 MHz)
NUM_KEYS, 80, width of the key state vector

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  synchronous, active-high reset
uart_rx_i  in  1  asynchronous serial input; idles high
keyboard_o  out  NUM_KEYS  key state; 1 = pressed; bit n = key index n
key_event_o  out  1  one-cycle pulse when a valid make/break updates keyboard_o
key_index_o  out  7  index of the last event; held between events
key_make_o  out  1  1 = last event was a make, 0 = break; held between events
frame_err_o  out  1  one-cycle pulse on a stop-bit error
err_count_o  out  8  frame error count; saturates at 255
timeout_o  out  1  one-cycle pulse when the timeout clears the key state

Behaviour:
- Reset values: all outputs are 0. The input synchroniser flops reset to 1. The receiver FSM resets to IDLE. The timeout counter resets to 0.
- Input path: uart_rx_i passes through a 2-FF synchroniser, then one further flop used for edge detection.
- Baud tick: DIV = round(CLK_HZ / (BAUD*16)), which is 27 at the defaults. The tick counter runs only when the FSM is outside IDLE and is cleared on entry to START.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START on a synchronised falling edge. A line that is already low at reset release is not a start bit.
  - START: at oversample tick 8 (mid-bit), a low line -> DATA; a high line -> IDLE (glitch rejected).
  - DATA: sample every 16 ticks, LSB first; after 8 bits -> STOP.
  - STOP: sample at mid-bit.
    - High: byte_valid is asserted for one cycle (cycle N); go to IDLE.
    - Low: frame_err_o pulses, err_count_o increments (saturating), the byte is discarded; go to BREAK.
  - BREAK -> IDLE once the synchronised line reads high.
- Byte decode (registered): outputs update in cycle N+1.
  - bit7 = 1 is a make, 0 is a break; idx = bits[6:0].
  - idx < NUM_KEYS: set (make) or clear (break) keyboard_o[idx]; load key_index_o and key_make_o; pulse key_event_o.
  - 0x7F: clear all of keyboard_o; pulse key_event_o with key_index_o = 127, key_make_o = 0.
  - idx 80..126 and 0xFF: ignored. No event and no error, but the byte still restarts the timeout counter.
- Timeout counter:
  - Cleared in every cycle N.
  - Otherwise increments, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC with keyboard_o != 0: clear keyboard_o, pulse timeout_o, clear the counter.
  - On reaching TIMEOUT_CYC with keyboard_o == 0: hold at saturation with no pulse.
- Simultaneous events: a byte decode in the same cycle as a timeout expiry wins. The timeout is suppressed and the counter clears. A make of an already-pressed key, or a break of a released key, still pulses key_event_o.
- Reset mid-frame: the partial byte is dropped, keyboard_o is cleared, and the FSM returns to IDLE. A fresh falling edge is required before the next byte is received.
- End-to-end latency: key_event_o rises 1 cycle after the stop-bit mid-sample.

Decomposition:
- Package key_uart_pkg:
  - constants KEY_COUNT = 80, CMD_RELEASE_ALL = 8'h7F, OVS = 16, MID_TICK = 8
  - receiver state enum {IDLE, START, DATA, STOP, BREAK}
  - a function computing DIV from CLK_HZ and BAUD
- One sub-module, uart_rx_8n1, covers the synchroniser, tick generator and FSM. Its outputs are data[7:0], byte_valid and frame_err.
- The top level holds the decode, key-state register, counters and timeout.

Test Plan:
- Defaults (432 clks/bit). Send 0x85 -> 1 cycle after stop mid-sample: keyboard_o[5] = 1, key_event_o = 1 for one cycle, key_index_o = 5, key_make_o = 1. Then send 0x05 -> keyboard_o = 0, key_make_o = 0.
- Send 0xC8, 0x81, then 0x7F -> keyboard_o[72] and keyboard_o[1] are set, then all clear; 3 key_event_o pulses; key_index_o = 127 after the last.
- Send 0xD0 (idx 80) -> no key_event_o, keyboard_o unchanged, no frame_err_o.
- Send 0x33 with stop bit driven low, line released high 2 bit-times later -> frame_err_o pulses once, err_count_o = 1, keyboard_o unchanged. Then send 0x82 -> keyboard_o[2] = 1.
- Drive a 3-cycle low glitch on uart_rx_i -> no byte, no error. Assert rst_i mid-byte after 0x84 set bit 4 -> keyboard_o = 0; a following full 0x86 is decoded correctly.
- TIMEOUT_CYC = 10000. Send 0x89 -> after 10000 idle clks, timeout_o pulses and keyboard_o = 0. With no keys pressed, no further timeout_o pulses occur.

Source files
------------

// File: rtl/key_uart_decoder_pkg.sv
// Shared constants, receiver state encoding and baud divisor helper
// for the serial key-event decoder.
package key_uart_pkg;

    localparam int         KEY_COUNT       = 80;
    localparam logic [7:0] CMD_RELEASE_ALL = 8'h7F;
    localparam int         OVS             = 16;
    localparam int         MID_TICK        = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clocks per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud * 8) / (baud * 16);
    endfunction

endpackage

// File: rtl/key_uart_decoder_uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling, input synchroniser and
// framing check; emits one-cycle byte_valid / frame_err pulses.
module uart_rx_8n1
    import key_uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_d;
    logic [1:0]      r_warm;
    rx_state_t       r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_ovs;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_tick;
    logic            w_fall;

    assign w_tick = (r_tick_cnt == TW'(DIV - 1));
    // Edges are only trusted once the chain holds real line samples, so a
    // line that is already low when reset releases never looks like a start.
    assign w_fall = (r_warm == 2'd3) && r_rx_d && !r_sync2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
            r_warm  <= 2'd0;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state == IDLE || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_ovs        <= 4'd0;
            r_bit        <= 3'd0;
            r_shift      <= 8'd0;
            data_o       <= 8'd0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ovs <= 4'd0;
                    if (w_fall)
                        r_state <= START;
                end
                START: begin
                    if (w_tick) begin
                        if (r_ovs == 4'(MID_TICK - 1)) begin
                            r_ovs   <= 4'd0;
                            r_bit   <= 3'd0;
                            r_state <= r_sync2 ? IDLE : DATA;
                        end else begin
                            r_ovs <= r_ovs + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_ovs == 4'(OVS - 1)) begin
                            r_ovs   <= 4'd0;
                            r_shift <= {r_sync2, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7)
                                r_state <= STOP;
                        end else begin
                            r_ovs <= r_ovs + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_ovs == 4'(OVS - 1)) begin
                            r_ovs <= 4'd0;
                            if (r_sync2) begin
                                data_o       <= r_shift;
                                byte_valid_o <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                frame_err_o <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_ovs <= r_ovs + 4'd1;
                        end
                    end
                end
                BREAK: begin
                    if (r_sync2)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_uart_decoder.sv
// Serial key make/break decoder: maintains the CPC key state vector,
// counts framing errors and releases stuck keys after an idle timeout.
module key_uart_decoder
    import key_uart_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int NUM_KEYS    = KEY_COUNT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                uart_rx_i,
    output logic [NUM_KEYS-1:0] keyboard_o,
    output logic                key_event_o,
    output logic [6:0]          key_index_o,
    output logic                key_make_o,
    output logic                frame_err_o,
    output logic [7:0]          err_count_o,
    output logic                timeout_o
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]          w_data;
    logic                w_byte_valid;
    logic                w_frame_err;
    logic [6:0]          w_idx;
    logic                w_make;
    logic [NUM_KEYS-1:0] r_kb;
    logic [TOW-1:0]      r_to_cnt;
    logic [7:0]          r_err_cnt;

    uart_rx_8n1 #(.DIV(DIV)) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (uart_rx_i),
        .data_o       (w_data),
        .byte_valid_o (w_byte_valid),
        .frame_err_o  (w_frame_err)
    );

    assign w_idx       = w_data[6:0];
    assign w_make      = w_data[7];
    assign keyboard_o  = r_kb;
    assign frame_err_o = w_frame_err;
    assign err_count_o = r_err_cnt;

    // Any received byte, even an ignored index, counts as link activity and
    // takes priority over a timeout expiring in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kb        <= '0;
            r_to_cnt    <= '0;
            key_event_o <= 1'b0;
            key_index_o <= 7'd0;
            key_make_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            key_event_o <= 1'b0;
            timeout_o   <= 1'b0;
            if (w_byte_valid) begin
                r_to_cnt <= '0;
                if (w_data == CMD_RELEASE_ALL) begin
                    r_kb        <= '0;
                    key_event_o <= 1'b1;
                    key_index_o <= 7'd127;
                    key_make_o  <= 1'b0;
                end else if (int'(w_idx) < NUM_KEYS) begin
                    r_kb[w_idx] <= w_make;
                    key_event_o <= 1'b1;
                    key_index_o <= w_idx;
                    key_make_o  <= w_make;
                end
            end else if (r_to_cnt == TOW'(TIMEOUT_CYC)) begin
                if (|r_kb) begin
                    r_kb      <= '0;
                    timeout_o <= 1'b1;
                    r_to_cnt  <= '0;
                end
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_err_cnt <= 8'd0;
        else if (w_frame_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_key_uart_decoder.sv
// Directed bench for key_uart_decoder: serial frames at 432 clocks/bit,
// framing errors, glitches, mid-frame reset and stuck-key timeout.
module tb_key_uart_decoder;

    localparam int BIT_CYC = 432;
    localparam int TO_CYC  = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [79:0] kb;
    logic        ev;
    logic [6:0]  idx;
    logic        mk;
    logic        fe;
    logic [7:0]  ec;
    logic        to;

    key_uart_decoder #(
        .CLK_HZ      (50000000),
        .BAUD        (115200),
        .TIMEOUT_CYC (TO_CYC),
        .NUM_KEYS    (80)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (rx),
        .keyboard_o  (kb),
        .key_event_o (ev),
        .key_index_o (idx),
        .key_make_o  (mk),
        .frame_err_o (fe),
        .err_count_o (ec),
        .timeout_o   (to)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ev_cnt = 0;
    int fe_cnt = 0;
    int to_cnt = 0;
    int last_ev_cyc = 0;
    int to_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (ev) begin
            ev_cnt++;
            last_ev_cyc = cyc;
        end
        if (fe) fe_cnt++;
        if (to) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Leaves the line at the stop-bit level so callers can stretch a bad stop.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    initial begin
        logic [79:0] exp_kb;
        int e0;
        int f0;
        int w;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_kb", kb, 80'd0);
        check("rst_ev", ev, 0);
        check("rst_idx", idx, 0);
        check("rst_make", mk, 0);
        check("rst_ferr", fe, 0);
        check("rst_errcnt", ec, 0);
        check("rst_timeout", to, 0);
        repeat (20) @(negedge clk);

        e0 = ev_cnt;
        send_frame(8'h85, 1'b1);
        exp_kb = '0; exp_kb[5] = 1'b1;
        check("make5_kb", kb, exp_kb);
        check("make5_idx", idx, 5);
        check("make5_make", mk, 1);
        check("make5_evcnt", ev_cnt - e0, 1);

        send_frame(8'h05, 1'b1);
        check("brk5_kb", kb, 80'd0);
        check("brk5_make", mk, 0);
        check("brk5_idx", idx, 5);

        e0 = ev_cnt;
        send_frame(8'hC8, 1'b1);
        exp_kb = '0; exp_kb[72] = 1'b1;
        check("make72_kb", kb, exp_kb);
        check("make72_idx", idx, 72);
        send_frame(8'h81, 1'b1);
        exp_kb[1] = 1'b1;
        check("make1_kb", kb, exp_kb);
        send_frame(8'h7F, 1'b1);
        check("relall_kb", kb, 80'd0);
        check("relall_idx", idx, 127);
        check("relall_make", mk, 0);
        check("relall_evcnt", ev_cnt - e0, 3);

        e0 = ev_cnt;
        f0 = fe_cnt;
        send_frame(8'hD0, 1'b1);
        check("idx80_evcnt", ev_cnt - e0, 0);
        check("idx80_kb", kb, 80'd0);
        check("idx80_fecnt", fe_cnt - f0, 0);
        check("idx80_idx", idx, 127);

        e0 = ev_cnt;
        send_frame(8'h33, 1'b0);
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        check("ferr_fecnt", fe_cnt - f0, 1);
        check("ferr_errcnt", ec, 1);
        check("ferr_kb", kb, 80'd0);
        check("ferr_evcnt", ev_cnt - e0, 0);

        send_frame(8'h82, 1'b1);
        exp_kb = '0; exp_kb[2] = 1'b1;
        check("make2_kb", kb, exp_kb);

        e0 = ev_cnt;
        f0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("glitch_evcnt", ev_cnt - e0, 0);
        check("glitch_fecnt", fe_cnt - f0, 0);
        check("glitch_kb", kb, exp_kb);

        send_frame(8'h84, 1'b1);
        exp_kb[4] = 1'b1;
        check("make4_kb", kb, exp_kb);

        rx = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);
        e0 = ev_cnt;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        check("midrst_kb", kb, 80'd0);
        check("midrst_idx", idx, 0);
        check("midrst_errcnt", ec, 0);
        check("midrst_evcnt", ev_cnt - e0, 0);

        send_frame(8'h86, 1'b1);
        exp_kb = '0; exp_kb[6] = 1'b1;
        check("make6_kb", kb, exp_kb);
        check("make6_idx", idx, 6);
        check("make6_make", mk, 1);
        check("pre_to_cnt", to_cnt, 0);

        send_frame(8'h89, 1'b1);
        exp_kb[9] = 1'b1;
        check("make9_kb", kb, exp_kb);
        w = 0;
        while (to_cnt == 0 && w < TO_CYC + 2000) begin
            @(negedge clk);
            w++;
        end
        check("to_pulsed", to_cnt, 1);
        check("to_latency", to_cyc - last_ev_cyc, TO_CYC + 1);
        check("to_kb", kb, 80'd0);
        repeat (TO_CYC + 2000) @(negedge clk);
        check("to_no_repeat", to_cnt, 1);
        check("to_kb_idle", kb, 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
